// File: rtl/gate_sweep_if.sv
// rtl/gate_sweep_if.sv - handshake and result bundle between the sweep controller and the gate set under test
interface gate_sweep_if;
    logic        start;
    logic        a_out;
    logic        b_out;
    logic [6:0]  g_in;
    logic        busy;
    logic        done;
    logic [27:0] table_out;
    logic        pass;
    logic [6:0]  fail_mask;

    modport master (
        input  start,
        input  g_in,
        output a_out,
        output b_out,
        output busy,
        output done,
        output table_out,
        output pass,
        output fail_mask
    );

    modport slave (
        output start,
        output g_in,
        input  a_out,
        input  b_out,
        input  busy,
        input  done,
        input  table_out,
        input  pass,
        input  fail_mask
    );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// rtl/gate_sweep_ctrl.sv - drives all four {a,b} combos into a shared gate set and captures the truth table
// Optional golden-value checking is built when GATE_SWEEP_CHECK_EN is defined.
module gate_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    gate_sweep_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    // Last settle count value; unused when SETTLE_CYCLES is 0 since DRIVE skips SETTLE.
    localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

    state_t      state;
    state_t      state_nx;
    logic [1:0]  combo;
    logic [3:0]  settle_cnt;
    logic [27:0] table_q;
    logic        accept;

    assign accept = (state == S_IDLE) && bus.start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nx = S_DRIVE;
                end
            end
            S_DRIVE: begin
                state_nx = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_nx = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                state_nx = (combo == 2'd3) ? S_DONE : S_DRIVE;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        bus.a_out = 1'b0;
        bus.b_out = 1'b0;
        case (state)
            S_DRIVE, S_SETTLE, S_SAMPLE: begin
                bus.busy  = 1'b1;
                bus.a_out = combo[1];
                bus.b_out = combo[0];
            end
            S_DONE: begin
                bus.done = 1'b1;
            end
            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end

    // Combo index stops at 3 so the DONE cycle still reflects the last combo swept.
    always_ff @(posedge clk) begin
        if (rst) begin
            combo      <= 2'd0;
            settle_cnt <= 4'd0;
            table_q    <= 28'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        combo      <= 2'd0;
                        settle_cnt <= 4'd0;
                        table_q    <= 28'd0;
                    end
                end
                S_DRIVE: begin
                    settle_cnt <= 4'd0;
                end
                S_SETTLE: begin
                    settle_cnt <= settle_cnt + 4'd1;
                end
                S_SAMPLE: begin
                    table_q[7*combo +: 7] <= bus.g_in;
                    if (combo != 2'd3) begin
                        combo <= combo + 2'd1;
                    end
                end
                default: begin
                    settle_cnt <= settle_cnt;
                end
            endcase
        end
    end

    assign bus.table_out = table_q;

`ifdef GATE_SWEEP_CHECK_EN
    logic [6:0] golden;
    logic [6:0] mism;
    logic [6:0] mask_q;
    logic       pass_q;

    // Bit order: XNOR XOR NOR NAND NOT(a) OR AND.
    always_comb begin
        golden = 7'b1011100;
        case (combo)
            2'd0: golden = 7'b1011100;
            2'd1: golden = 7'b0101110;
            2'd2: golden = 7'b0101010;
            2'd3: golden = 7'b1000011;
            default: golden = 7'b1011100;
        endcase
    end

    assign mism = bus.g_in ^ golden;

    // pass is resolved at the edge into DONE, folding in the final combo's mismatches.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= 7'd0;
            pass_q <= 1'b0;
        end else if (accept) begin
            mask_q <= 7'd0;
            pass_q <= 1'b0;
        end else if (state == S_SAMPLE) begin
            mask_q <= mask_q | mism;
            if (combo == 2'd3) begin
                pass_q <= ((mask_q | mism) == 7'd0);
            end
        end
    end

    assign bus.fail_mask = mask_q;
    assign bus.pass      = pass_q;
`else
    assign bus.fail_mask = 7'd0;
    assign bus.pass      = 1'b0;
`endif

endmodule
